reset_sequencer: RTL
====================

# reset_sequencer

Parametrised board-level reset sequencer for processor-array tops. Synchronises the external reset, releases a configurable number of downstream reset domains in a fixed staggered order, and supports a synchronised soft-reset request that re-runs the sequence. It also provides READY, a soft-reset counter and an optional heartbeat for board LEDs. It sits between the clock buffer and the processing fabric / UART in each top.

## Interface
- NUM_DOMAINS, 4: number of reset outputs, legal range 1..16.
- SYNC_STAGES, 4: reset synchroniser depth, minimum 2.
- STAGGER_CYCLES, 8: cycles between consecutive domain releases, minimum 1.
- HOLD_CYCLES, 16: minimum soft-reset assertion length in cycles, minimum 1.
- HB_DIV_LOG2, 24: heartbeat half-period is 2^HB_DIV_LOG2 cycles.

- CLK  in  1  single clock, already buffered.
- RST  in  1  asynchronous, active-low reset.
- SOFT_RST  in  1  asynchronous soft-reset request (switch/UART); only its rising edge acts.
- DOM_RST  out  NUM_DOMAINS  per-domain reset, active-high.
- READY  out  1  high when all domains are released.
- RST_COUNT  out  8  number of soft resets performed, saturating.
- HB  out  1  heartbeat LED.

## Operation
- Reset values (RST low): DOM_RST all 1, READY 0, RST_COUNT 0, HB 0, state SYNC, synchroniser chain all 1, soft-request synchroniser 0.
- RST assertion takes effect asynchronously in every state: all outputs return to their reset values immediately.
- Synchroniser: SYNC_STAGES flops, asynchronously set by RST; 0 shifts in after RST deasserts. rst_sync is the last stage.
- SOFT_RST path: 2-flop synchroniser, then one delay flop. soft_edge = sync & ~delayed.
- FSM states:
  - SYNC: stays while rst_sync=1. Moves to RELEASE on the first edge with rst_sync=0; DOM_RST[0] clears on that same edge. Counter = 0, index = 1.
  - RELEASE: counter counts to STAGGER_CYCLES-1, then wraps to 0. On each wrap, DOM_RST[index] clears and index increments. After DOM_RST[NUM_DOMAINS-1] clears, go to RUN on the next edge and set READY. If NUM_DOMAINS=1, go directly SYNC→RELEASE→RUN.
  - RUN: READY=1. On soft_edge, go to HOLD: all DOM_RST=1, READY=0, RST_COUNT increments, saturating at 255.
  - HOLD: counts HOLD_CYCLES cycles, then enters RELEASE with DOM_RST[0] cleared and index = 1.
- soft_edge in RELEASE: restart into HOLD (all DOM_RST=1) and increment RST_COUNT.
- soft_edge in HOLD: restart the hold count. RST_COUNT does not increment.
- soft_edge in SYNC: ignored.
- A released domain never re-asserts except through HOLD or RST. Release order is always index 0 → NUM_DOMAINS-1.
- Counter width is $clog2(max(STAGGER_CYCLES, HOLD_CYCLES)+1). Index width is $clog2(NUM_DOMAINS)+1.

## Timing
- Let E1 be the first CLK rising edge with RST high.
  - rst_sync falls after E(SYNC_STAGES).
  - DOM_RST[i] falls after E(SYNC_STAGES+1+i*STAGGER_CYCLES).
  - READY rises one edge after the last release.
- With defaults: DOM_RST[0..3] fall after E5, E13, E21, E29; READY rises after E30.
- Soft reset: let Ek be the first edge sampling SOFT_RST high.
  - DOM_RST all 1 and READY 0 after E(k+2).
  - DOM_RST[0] falls after E(k+2+HOLD_CYCLES); later domains follow the same stagger.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- RESET_SEQ_HEARTBEAT_EN defined: a free-running HB_DIV_LOG2-bit counter runs while READY=1 and clears while READY=0. HB toggles on every counter wrap; HB is forced to 0 when READY=0.
- RESET_SEQ_HEARTBEAT_EN undefined: no counter is instantiated and HB is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Power-up, defaults: hold RST low 5 cycles, then release → DOM_RST=4'b1111 until E5; 4'b1110 after E5, 4'b1100 after E13, 4'b1000 after E21, 4'b0000 after E29; READY=1 after E30.
- Soft reset in RUN: pulse SOFT_RST 3 cycles → DOM_RST=4'b1111 and READY=0 two edges after first sample. Release resumes 16 cycles later with 8-cycle stagger. RST_COUNT=1.
- Soft reset during RELEASE: pulse when DOM_RST=4'b1100 → all 1s again, full 16-cycle hold, then the full sequence restarts from domain 0. RST_COUNT=1.
- Async reset mid-sequence: drive RST low between CLK edges in RELEASE → DOM_RST=all 1s, READY=0, RST_COUNT=0 before the next edge. Re-release → timing identical to power-up.
- Saturation and edge filter:
  - 300 soft pulses with full recovery between each → RST_COUNT=255.
  - SOFT_RST held high 1000 cycles → exactly one soft reset.
- Heartbeat, HB_DIV_LOG2=3, macro defined → HB toggles every 8 cycles after READY and is 0 during HOLD. Same bench with macro undefined → HB constantly 0.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
//   Groups the soft-reset request and the sequencer's status outputs.
//   Parameter NUM_DOMAINS sets the width of dom_rst and must match the
//   sequencer instance it connects to.
//
//   Signals:
//     soft_rst   asynchronous soft-reset request (rising edge acts)
//     dom_rst    per-domain reset, active-high
//     ready      high when every domain is released
//     rst_count  saturating count of soft resets performed
//     hb         heartbeat LED
//     state      FSM state for debug/checkers (0 SYNC, 1 RELEASE, 2 RUN, 3 HOLD)
//
//   Handshake: there is no valid/ready transfer on this interface. soft_rst
//   is a level request whose rising edge starts one soft reset; ready is a
//   level status, not a flow-control signal, and carries no acknowledge.
//
//   Modports: master = sequencer side, slave = board/fabric side.
`timescale 1ns/1ps

interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   soft_rst;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   ready;
  logic [7:0]             rst_count;
  logic                   hb;
  logic [1:0]             state;

  modport master (
    input  soft_rst,
    output dom_rst, ready, rst_count, hb, state
  );

  modport slave (
    output soft_rst,
    input  dom_rst, ready, rst_count, hb, state
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Board-level reset sequencer. Synchronises the external reset, releases
//   NUM_DOMAINS downstream resets in order 0..NUM_DOMAINS-1 spaced by
//   STAGGER_CYCLES, and re-runs the sequence after a synchronised soft-reset
//   request (held for at least HOLD_CYCLES). All outputs are registered.
//
//   Ports:
//     clk    single buffered clock
//     rst_n  asynchronous active-low reset
//     bus    reset_sequencer_if.master (soft_rst in; dom_rst, ready,
//            rst_count, hb, state out)
//
//   Build option: define RESET_SEQ_HEARTBEAT_EN to get a heartbeat on hb
//   that toggles every 2^HB_DIV_LOG2 cycles while ready is high. Without it
//   hb is tied low and no heartbeat counter exists.
`timescale 1ns/1ps

module reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int SYNC_STAGES    = 4,
  parameter int STAGGER_CYCLES = 8,
  parameter int HOLD_CYCLES    = 16,
  parameter int HB_DIV_LOG2    = 24
) (
  input logic              clk,
  input logic              rst_n,
  reset_sequencer_if.master bus
);

  localparam int CNT_MAX = (STAGGER_CYCLES > HOLD_CYCLES) ? STAGGER_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_DOMAINS) + 1;

  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_DONE  = IDX_W'(NUM_DOMAINS);

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  // External reset synchroniser: set asynchronously, zeros shift in after release.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  // Soft-reset request: two-flop synchroniser plus a delay flop for edge detect.
  logic soft_s1_q, soft_s2_q, soft_dly_q;
  logic soft_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      soft_s1_q  <= 1'b0;
      soft_s2_q  <= 1'b0;
      soft_dly_q <= 1'b0;
    end else begin
      soft_s1_q  <= bus.soft_rst;
      soft_s2_q  <= soft_s1_q;
      soft_dly_q <= soft_s2_q;
    end
  end

  assign soft_edge = soft_s2_q & ~soft_dly_q;

  // Sequencer state and registered outputs.
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic [7:0]             count_q, count_d;
  logic [7:0]             count_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '1;
      ready_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      ready_q <= ready_d;
      count_q <= count_d;
    end
  end

  assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    ready_d = ready_q;
    count_d = count_q;

    unique case (state_q)
      S_SYNC: begin
        // Soft requests are ignored until the external reset has been released.
        if (!rst_sync) begin
          state_d  = S_RELEASE;
          dom_d[0] = 1'b0;
          cnt_d    = '0;
          idx_d    = IDX_W'(1);
        end
      end

      S_RELEASE: begin
        if (soft_edge) begin
          state_d = S_HOLD;
          dom_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
          count_d = count_inc;
        end else if (idx_q == IDX_DONE) begin
          // Last domain was released on the previous edge.
          state_d = S_RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == STAG_LAST) begin
          cnt_d = '0;
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (idx_q == IDX_W'(i)) dom_d[i] = 1'b0;
          end
          idx_d = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RUN: begin
        if (soft_edge) begin
          state_d = S_HOLD;
          dom_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
          count_d = count_inc;
        end
      end

      S_HOLD: begin
        // A fresh request while holding only stretches the hold.
        if (soft_edge) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d  = S_RELEASE;
          dom_d[0] = 1'b0;
          cnt_d    = '0;
          idx_d    = IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_SYNC;
      end
    endcase
  end

  assign bus.dom_rst   = dom_q;
  assign bus.ready     = ready_q;
  assign bus.rst_count = count_q;
  assign bus.state     = state_q;

`ifdef RESET_SEQ_HEARTBEAT_EN
  logic [HB_DIV_LOG2-1:0] hb_cnt_q;
  logic                   hb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else if (!ready_q) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_q + HB_DIV_LOG2'(1);
      if (&hb_cnt_q) hb_q <= ~hb_q;
    end
  end

  // Gate with ready so hb drops on the same edge ready does.
  assign bus.hb = hb_q & ready_q;
`else
  // No heartbeat in this build; the divider parameter only keeps the
  // parameter list identical between builds.
  assign bus.hb = 1'b0 & (HB_DIV_LOG2 > 0);
`endif

endmodule
